// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Stale responses can pile up across back-to-back redirects, so the drop counter is wider than the fetch cap.
    localparam int DISCARD_W = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and the memory (slave).
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO with synchronous clear; pop is applied before push so a full FIFO accepts push+pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_en  = pop && (count_q != '0);
    assign push_en = push && ((count_q != CNT_W'(DEPTH)) || pop_en);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: every _d gets its hold value first, so no branch can leave it undriven and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_en && !clr) mem_q[wr_ptr_q] <= push_data;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, presents one {pc, inst} per cycle.
// Define FETCH_PERF_EN to add bubble_cnt_o, a saturating count of unstalled bubble cycles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2,
    parameter int          PC_STEP   = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    fetch_if.master     imem,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int CNT_W = cnt_width(BUF_DEPTH);

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0]     fifo_count, pcq_count;
    logic [CNT_W:0]       inflight;
    logic                 issue, resp_drop, resp_keep, pop;
    fetch_entry_t         fifo_head, fifo_push_data;
    logic [31:0]          pcq_head;

    // Reset asserts asynchronously but releases on a clock edge for everything downstream.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end
    assign rst_n = rst_sync_q[1];

    // Live in-flight fetches (pc queue occupancy) plus buffered words never exceed BUF_DEPTH.
    assign inflight       = {1'b0, pcq_count} + {1'b0, fifo_count};
    assign imem.imem_req  = rst_n && !redirect_i && (inflight < (CNT_W+1)'(BUF_DEPTH));
    assign imem.imem_addr = fetch_pc_q;

    assign issue     = imem.imem_req && imem.imem_gnt;
    assign resp_drop = imem.imem_rvalid && (discard_q != '0);
    assign resp_keep = imem.imem_rvalid && (discard_q == '0);
    assign pop       = valid_o && !stall_i;

    assign fifo_push_data = '{pc: pcq_head, inst: imem.imem_rdata};

    fetch_fifo #(.DEPTH(BUF_DEPTH), .entry_t(fetch_entry_t)) u_data_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n),
        .clr       (redirect_i),
        .push      (resp_keep),
        .push_data (fifo_push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH), .entry_t(logic [31:0])) u_pc_queue (
        .clk       (clk_i),
        .rst_n     (rst_n),
        .clr       (redirect_i),
        .push      (issue),
        .push_data (imem.imem_addr),
        .pop       (resp_keep),
        .head      (pcq_head),
        .count     (pcq_count)
    );

    assign valid_o = (fifo_count != '0);

    always_comb begin
        pc_o   = '0;
        inst_o = INST_NOP;
        if (valid_o) begin
            pc_o   = fifo_head.pc;
            inst_o = fifo_head.inst;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            // Everything still in flight turns stale; a response landing this cycle is one of them.
            discard_d  = discard_q + DISCARD_W'(pcq_count) + DISCARD_W'(issue)
                         - DISCARD_W'(imem.imem_rvalid);
        end else begin
            if (issue)     fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
            if (resp_drop) discard_d  = discard_q - DISCARD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!valid_o && !stall_i && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) bubble_cnt_q <= '0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural in-order, variable-latency instruction memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk_i, rst_n_i, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] pc_o, inst_o;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_o;
`endif

    fetch_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2), .PC_STEP(4)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem_bus),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
`ifdef FETCH_PERF_EN
        ,
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;
    bit hold_gnt = 0;
    int mcyc     = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mresp_t;
    mresp_t mq[$];

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    // Memory word at address a is {16'hC0DE, a[15:0]}; decisions are made at the falling edge.
    initial begin
        imem_bus.imem_gnt    = 0;
        imem_bus.imem_rvalid = 0;
        imem_bus.imem_rdata  = '0;
        forever begin
            @(negedge clk_i);
            mcyc++;
            if (!rst_n_i) begin
                mq.delete();
                imem_bus.imem_gnt    = 0;
                imem_bus.imem_rvalid = 0;
                imem_bus.imem_rdata  = '0;
            end else begin
                if (mq.size() > 0 && mq[0].due <= mcyc) begin
                    imem_bus.imem_rvalid = 1;
                    imem_bus.imem_rdata  = {16'hC0DE, mq[0].addr[15:0]};
                    void'(mq.pop_front());
                end else begin
                    imem_bus.imem_rvalid = 0;
                    imem_bus.imem_rdata  = '0;
                end
                imem_bus.imem_gnt = imem_bus.imem_req && !hold_gnt;
                if (imem_bus.imem_req && !hold_gnt)
                    mq.push_back('{addr: imem_bus.imem_addr, due: mcyc + mem_lat});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic hold_reset();
        next_cycle();
        rst_n_i    = 0;
        redirect_i = 0;
        repeat (3) next_cycle();
    endtask

    // Releases reset and returns at the falling edge of the first cycle with imem_req_o high.
    task automatic release_reset(input string tag);
        bit found;
        found   = 0;
        rst_n_i = 1;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk_i);
            if (imem_bus.imem_req) found = 1;
        end
        check({tag, "_first_req"}, 32'(found), 32'd1);
        check({tag, "_first_addr"}, imem_bus.imem_addr, 32'h0000_0000);
    endtask

    // Waits for the next valid output, checking every bubble on the way shows pc_o = inst_o = 0.
    task automatic expect_next(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        bit seen;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1;
            else check({tag, "_bubble"}, pc_o | inst_o, 32'h0);
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_pc"}, pc_o, exp_pc);
        check({tag, "_inst"}, inst_o, exp_inst);
    endtask

    initial begin
        rst_n_i       = 1;
        stall_i       = 0;
        redirect_i    = 0;
        redirect_pc_i = '0;
        #2 rst_n_i = 0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_req",   32'(imem_bus.imem_req), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_pc",    pc_o, 32'h0);
        check("rst_inst",  inst_o, 32'h0);

        // Streaming with 1-cycle latency: valid two cycles after the first request
        mem_lat = 1;
        next_cycle();
        release_reset("s1");
        check("s1_c0_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        check("s1_c1_valid", 32'(valid_o), 32'd0);
        check("s1_c1_inst",  inst_o, 32'h0);
        @(negedge clk_i);
        check("s1_c2_valid", 32'(valid_o), 32'd1);
        check("s1_c2_pc",    pc_o, 32'h0000_0000);
        check("s1_c2_inst",  inst_o, 32'hC0DE_0000);
        expect_next("s1_pc4", 32'h0000_0004, 32'hC0DE_0004);
        expect_next("s1_pc8", 32'h0000_0008, 32'hC0DE_0008);

        // Stall until the FIFO fills, then hold for several cycles
        next_cycle();
        stall_i = 1;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("s2_hold%0d_valid", i), 32'(valid_o), 32'd1);
            check($sformatf("s2_hold%0d_pc", i),    pc_o, 32'h0000_000C);
            check($sformatf("s2_hold%0d_inst", i),  inst_o, 32'hC0DE_000C);
            check($sformatf("s2_hold%0d_req", i),   32'(imem_bus.imem_req), 32'd0);
        end
        next_cycle();
        stall_i = 0;
        expect_next("s2_pcC",  32'h0000_000C, 32'hC0DE_000C);
        expect_next("s2_pc10", 32'h0000_0010, 32'hC0DE_0010);
        expect_next("s2_pc14", 32'h0000_0014, 32'hC0DE_0014);

        // Redirect with two fetches outstanding at latency 3
        hold_reset();
        mem_lat = 3;
        release_reset("s3");
        next_cycle();
        next_cycle();
        redirect_i    = 1;
        redirect_pc_i = 32'h0000_0100;
        @(negedge clk_i);
        check("s3_redir_req", 32'(imem_bus.imem_req), 32'd0);
        next_cycle();
        redirect_i = 0;
        @(negedge clk_i);
        check("s3_tgt_req",   32'(imem_bus.imem_req), 32'd1);
        check("s3_tgt_addr",  imem_bus.imem_addr, 32'h0000_0100);
        check("s3_tgt_valid", 32'(valid_o), 32'd0);
        expect_next("s3_pc100", 32'h0000_0100, 32'hC0DE_0100);
        expect_next("s3_pc104", 32'h0000_0104, 32'hC0DE_0104);

        // Redirect and stall together: redirect flushes the full FIFO
        hold_reset();
        mem_lat = 1;
        stall_i = 1;
        release_reset("s4");
        repeat (3) @(negedge clk_i);
        check("s4_full_valid", 32'(valid_o), 32'd1);
        check("s4_full_pc",    pc_o, 32'h0000_0000);
        check("s4_full_req",   32'(imem_bus.imem_req), 32'd0);
        next_cycle();
        redirect_i    = 1;
        redirect_pc_i = 32'h0000_0200;
        next_cycle();
        redirect_i = 0;
        @(negedge clk_i);
        check("s4_flush_valid", 32'(valid_o), 32'd0);
        check("s4_flush_inst",  inst_o, 32'h0);
        check("s4_tgt_req",     32'(imem_bus.imem_req), 32'd1);
        check("s4_tgt_addr",    imem_bus.imem_addr, 32'h0000_0200);
        next_cycle();
        stall_i = 0;
        expect_next("s4_pc200", 32'h0000_0200, 32'hC0DE_0200);

        // Grant withheld for four cycles
        hold_reset();
        hold_gnt = 1;
        release_reset("s5");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            check($sformatf("s5_wait%0d_req", i),   32'(imem_bus.imem_req), 32'd1);
            check($sformatf("s5_wait%0d_addr", i),  imem_bus.imem_addr, 32'h0000_0000);
            check($sformatf("s5_wait%0d_valid", i), 32'(valid_o), 32'd0);
            check($sformatf("s5_wait%0d_inst", i),  inst_o, 32'h0);
        end
        next_cycle();
        hold_gnt = 0;
        expect_next("s5_pc0", 32'h0000_0000, 32'hC0DE_0000);

        // Redirect coinciding with a live response, then sequential fetch across the 32-bit wrap
        hold_reset();
        release_reset("s6");
        next_cycle();
        redirect_i    = 1;
        redirect_pc_i = 32'hFFFF_FFFC;
        next_cycle();
        redirect_i = 0;
        @(negedge clk_i);
        check("s6_tgt_req",   32'(imem_bus.imem_req), 32'd1);
        check("s6_tgt_addr",  imem_bus.imem_addr, 32'hFFFF_FFFC);
        check("s6_tgt_valid", 32'(valid_o), 32'd0);
        expect_next("s6_pcTop",  32'hFFFF_FFFC, 32'hC0DE_FFFC);
        expect_next("s6_pcWrap", 32'h0000_0000, 32'hC0DE_0000);

        // Reset pulsed mid-stream while an instruction is presented
        #2 rst_n_i = 0;
        #1;
        check("s7_async_valid", 32'(valid_o), 32'd0);
        check("s7_async_pc",    pc_o, 32'h0);
        check("s7_async_inst",  inst_o, 32'h0);
        check("s7_async_req",   32'(imem_bus.imem_req), 32'd0);
        repeat (3) next_cycle();
        release_reset("s7");
        check("s7_after_valid", 32'(valid_o), 32'd0);
        expect_next("s7_pc0", 32'h0000_0000, 32'hC0DE_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
